vdp_vram_slot_arbiter: RTL and testbench

//  Shares the single 32-bit VRAM/SDRAM access slot per dot between three requesters: display fetch
//  (super-high-res), CPU port and command engine. Slots are sequenced by dot_state:
//  AP=3 (address present), FS=2 (fetch start), DL=0 (data loading), DR=1 (data ready).

---
 rtl/vdp_vram_slot_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vdp_vram_slot_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_vram_slot_arbiter.sv
// vdp_vram_slot_arbiter
// Shares the single 32-bit VRAM access slot per dot between the display
// fetcher, the CPU port and the command engine. dot_state sequences the slot
// as AP(3) -> FS(2) -> DL(0) -> DR(1). The grant is taken on the AP edge and
// the CPU/cmd transfer completes (ack + read capture) on the DR edge.
// Optional build macro VRAM_ARB_WATCHDOG_EN adds per-requester starvation
// counters that force a CPU/cmd slot over the display.
module vdp_vram_slot_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        dot_state,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cmd_req,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ack,
  output logic [DATA_W-1:0] cmd_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic [1:0]        slot_owner,
  output logic              starve_force
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_CMD  = 2'd3
  } owner_t;

  localparam logic [1:0] DS_AP = 2'd3;
  localparam logic [1:0] DS_DR = 2'd1;

  // The starvation counters are 4 bits wide, so the limit has to fit them.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must fit the 4-bit starvation counter");
  end

  owner_t owner_q;
  owner_t rr_grant;
  owner_t grant;
  logic   last_cmd;     // 1 when the command engine was the last CPU/cmd winner
  logic   force_grant;

  assign slot_owner = owner_q;

`ifdef VRAM_ARB_WATCHDOG_EN
  logic [3:0] cpu_cnt;
  logic [3:0] cmd_cnt;
  logic       cpu_starve;
  logic       cmd_starve;
  logic       force_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // A requester is starving when this AP would be its STARVE_LIMIT-th loss.
  assign cpu_starve   = cpu_req && (cpu_cnt >= 4'(STARVE_LIMIT - 1));
  assign cmd_starve   = cmd_req && (cmd_cnt >= 4'(STARVE_LIMIT - 1));
  assign starve_force = force_q;
`else
  assign starve_force = 1'b0;
`endif

  // Round-robin pick between CPU and cmd; on a tie the one not served last wins.
  always_comb begin
    rr_grant = OWN_IDLE;
    if (cpu_req && cmd_req) rr_grant = last_cmd ? OWN_CPU : OWN_CMD;
    else if (cpu_req)       rr_grant = OWN_CPU;
    else if (cmd_req)       rr_grant = OWN_CMD;
  end

  // Slot winner: forced starvation slot > display > round-robin.
  always_comb begin
    grant       = rr_grant;
    force_grant = 1'b0;
    if (disp_active) grant = OWN_DISP;
`ifdef VRAM_ARB_WATCHDOG_EN
    if (cpu_starve) begin
      grant       = OWN_CPU;
      force_grant = 1'b1;
    end else if (cmd_starve) begin
      grant       = OWN_CMD;
      force_grant = 1'b1;
    end
`endif
  end

  // Slot sequencing: grant and memory command on AP, completion on DR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= OWN_IDLE;
      last_cmd   <= 1'b1;
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
      cpu_ack    <= 1'b0;
      cmd_ack    <= 1'b0;
      cpu_rdata  <= '0;
      cmd_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cmd_ack <= 1'b0;
      if (dot_state == DS_AP) begin
        owner_q <= grant;
        vram_we <= 1'b0;
        case (grant)
          OWN_DISP: vram_addr <= disp_addr;
          OWN_CPU: begin
            vram_addr  <= cpu_addr;
            vram_we    <= cpu_we;
            vram_wdata <= cpu_wdata;
            last_cmd   <= 1'b0;
          end
          OWN_CMD: begin
            vram_addr  <= cmd_addr;
            vram_we    <= cmd_we;
            vram_wdata <= cmd_wdata;
            last_cmd   <= 1'b1;
          end
          default: ;
        endcase
      end else if (dot_state == DS_DR) begin
        // vram_we still reflects this slot, so it tells reads from writes.
        vram_we <= 1'b0;
        if (owner_q == OWN_CPU) begin
          cpu_ack <= 1'b1;
          if (!vram_we) cpu_rdata <= vram_rdata;
        end else if (owner_q == OWN_CMD) begin
          cmd_ack <= 1'b1;
          if (!vram_we) cmd_rdata <= vram_rdata;
        end
      end
    end
  end

`ifdef VRAM_ARB_WATCHDOG_EN
  // Starvation counters: count lost APs while requesting, clear on grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_cnt <= 4'd0;
      cmd_cnt <= 4'd0;
      force_q <= 1'b0;
    end else if (dot_state == DS_AP) begin
      force_q <= force_grant;
      if (grant == OWN_CPU) cpu_cnt <= 4'd0;
      else if (cpu_req)     cpu_cnt <= sat_inc(cpu_cnt);
      if (grant == OWN_CMD) cmd_cnt <= 4'd0;
      else if (cmd_req)     cmd_cnt <= sat_inc(cmd_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_vdp_vram_slot_arbiter.sv
// Directed bench for vdp_vram_slot_arbiter. Inputs change 1 time unit after
// each rising edge; outputs are sampled at that same point.
module tb_vdp_vram_slot_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        dot_state;
  logic              disp_active;
  logic [ADDR_W-1:0] disp_addr;
  logic              cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cmd_req, cmd_we, cmd_ack;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata, cmd_rdata;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [DATA_W-1:0] vram_wdata, vram_rdata;
  logic [1:0]        slot_owner;
  logic              starve_force;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vdp_vram_slot_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n), .dot_state(dot_state),
    .disp_active(disp_active), .disp_addr(disp_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .slot_owner(slot_owner), .starve_force(starve_force)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: wait for the edge, then advance the slot phase 3->2->0->1->3.
  task automatic clk1();
    @(posedge clk);
    #1;
    case (dot_state)
      2'd3:    dot_state = 2'd2;
      2'd2:    dot_state = 2'd0;
      2'd0:    dot_state = 2'd1;
      default: dot_state = 2'd3;
    endcase
  endtask

  // Advance until the next edge is an AP edge (at most 3 clocks).
  task automatic goto_ap();
    for (int i = 0; i < 4 && dot_state != 2'd3; i++) clk1();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n     = 1'b0;
    dot_state   = 2'd3;
    disp_active = 1'b0;
    disp_addr   = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    vram_rdata  = 32'hDEADBEEF;

    // Reset state
    clk1(); clk1();
    check("rst_owner", 32'(slot_owner), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_cmd_ack", 32'(cmd_ack), 32'd0);
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_addr", 32'(vram_addr), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_starve", 32'(starve_force), 32'd0);
    reset_n = 1'b1;

    // Round-robin CPU/cmd alternation, CPU first
    goto_ap();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00100;
    cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 17'h00200;
    clk1();
    check("rr1_owner", 32'(slot_owner), 32'd2);
    check("rr1_addr", 32'(vram_addr), 32'h00100);
    clk1(); clk1();
    check("rr1_no_early_ack", 32'(cpu_ack), 32'd0);
    clk1();
    check("rr1_cpu_ack", 32'(cpu_ack), 32'd1);
    check("rr1_cmd_ack", 32'(cmd_ack), 32'd0);
    check("rr1_rdata", cpu_rdata, 32'hDEADBEEF);
    vram_rdata = 32'hCAFEF00D;
    clk1();
    check("rr2_owner", 32'(slot_owner), 32'd3);
    check("rr2_addr", 32'(vram_addr), 32'h00200);
    check("rr1_ack_width", 32'(cpu_ack), 32'd0);
    clk1(); clk1(); clk1();
    check("rr2_cmd_ack", 32'(cmd_ack), 32'd1);
    check("rr2_cmd_rdata", cmd_rdata, 32'hCAFEF00D);
    check("rr2_cpu_ack", 32'(cpu_ack), 32'd0);
    clk1();
    check("rr3_owner", 32'(slot_owner), 32'd2);
    check("rr2_ack_width", 32'(cmd_ack), 32'd0);
    // Requests dropped mid-slot: the slot still completes and acks
    cpu_req = 1'b0; cmd_req = 1'b0;
    clk1(); clk1(); clk1();
    check("rr3_dropped_ack", 32'(cpu_ack), 32'd1);
    check("rr3_rdata", cpu_rdata, 32'hCAFEF00D);
    clk1();
    check("idle_owner", 32'(slot_owner), 32'd0);
    check("idle_addr_hold", 32'(vram_addr), 32'h00100);
    check("idle_we", 32'(vram_we), 32'd0);
    vram_rdata = 32'hDEADBEEF;

    // Display priority, then CPU read once display drops
    disp_active = 1'b1; disp_addr = 17'h04000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
    goto_ap();
    clk1();
    check("disp1_owner", 32'(slot_owner), 32'd1);
    check("disp1_addr", 32'(vram_addr), 32'h04000);
    check("disp1_we", 32'(vram_we), 32'd0);
    clk1(); clk1(); clk1();
    check("disp1_no_ack", 32'(cpu_ack), 32'd0);
    disp_addr = 17'h04002;
    clk1();
    check("disp2_owner", 32'(slot_owner), 32'd1);
    check("disp2_addr", 32'(vram_addr), 32'h04002);
    disp_active = 1'b0;
    clk1();
    check("disp_mid_drop_owner", 32'(slot_owner), 32'd1);
    clk1(); clk1();
    check("disp2_no_ack", 32'(cpu_ack), 32'd0);
    clk1();
    check("cpu_after_disp_owner", 32'(slot_owner), 32'd2);
    check("cpu_after_disp_addr", 32'(vram_addr), 32'h00010);
    clk1(); clk1(); clk1();
    check("cpu_after_disp_ack", 32'(cpu_ack), 32'd1);
    check("cpu_after_disp_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;

    // Command write at the top address
    cmd_req = 1'b1; cmd_we = 1'b1; cmd_addr = 17'h1FFFF; cmd_wdata = 32'h12345678;
    goto_ap();
    clk1();
    check("wr_owner", 32'(slot_owner), 32'd3);
    check("wr_we_ap", 32'(vram_we), 32'd1);
    check("wr_addr", 32'(vram_addr), 32'h1FFFF);
    check("wr_wdata", vram_wdata, 32'h12345678);
    clk1();
    check("wr_we_fs", 32'(vram_we), 32'd1);
    clk1();
    check("wr_we_dl", 32'(vram_we), 32'd1);
    cmd_req = 1'b0;
    clk1();
    check("wr_cmd_ack", 32'(cmd_ack), 32'd1);
    check("wr_we_clear", 32'(vram_we), 32'd0);
    check("wr_rdata_kept", cmd_rdata, 32'hCAFEF00D);

    // Request raised the clock after AP waits for the next AP
    goto_ap();
    clk1();
    check("late_idle_owner", 32'(slot_owner), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00ABC;
    clk1(); clk1(); clk1();
    check("late_not_granted", 32'(slot_owner), 32'd0);
    check("late_no_ack", 32'(cpu_ack), 32'd0);
    clk1();
    check("late_owner", 32'(slot_owner), 32'd2);
    clk1(); clk1();
    check("late_ack_6", 32'(cpu_ack), 32'd0);
    clk1();
    check("late_ack_7", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;

    // Reset asserted during DL of a CPU write slot
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00055; cpu_wdata = 32'hA5A5A5A5;
    goto_ap();
    clk1();
    check("mid_owner", 32'(slot_owner), 32'd2);
    check("mid_we", 32'(vram_we), 32'd1);
    clk1();
    reset_n = 1'b0;
    #1;
    check("mid_rst_owner", 32'(slot_owner), 32'd0);
    check("mid_rst_we", 32'(vram_we), 32'd0);
    check("mid_rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("mid_rst_addr", 32'(vram_addr), 32'd0);
    clk1();
    reset_n = 1'b1;
    cpu_req = 1'b0;
    clk1();
    check("mid_rel_no_ack", 32'(cpu_ack), 32'd0);
    check("mid_rel_owner", 32'(slot_owner), 32'd0);

`ifdef VRAM_ARB_WATCHDOG_EN
    // Starved CPU is forced over the display on the 8th lost AP
    disp_active = 1'b1; disp_addr = 17'h08000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00777;
    vram_rdata = 32'h0BADF00D;
    goto_ap();
    for (int ap = 1; ap <= 7; ap++) begin
      clk1();
      check("wd_disp_owner", 32'(slot_owner), 32'd1);
      check("wd_no_force", 32'(starve_force), 32'd0);
      clk1(); clk1(); clk1();
    end
    clk1();
    check("wd_forced_owner", 32'(slot_owner), 32'd2);
    check("wd_force_ap", 32'(starve_force), 32'd1);
    check("wd_forced_addr", 32'(vram_addr), 32'h00777);
    clk1();
    check("wd_force_fs", 32'(starve_force), 32'd1);
    clk1();
    check("wd_force_dl", 32'(starve_force), 32'd1);
    cpu_req = 1'b0;
    clk1();
    check("wd_force_dr", 32'(starve_force), 32'd1);
    check("wd_ack", 32'(cpu_ack), 32'd1);
    check("wd_rdata", cpu_rdata, 32'h0BADF00D);
    clk1();
    check("wd_back_to_disp", 32'(slot_owner), 32'd1);
    check("wd_force_clear", 32'(starve_force), 32'd0);
    disp_active = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
